// File: rtl/donut_pkg.sv
// Shared types and default geometry for the donut animation frame reader.
package donut_pkg;
  localparam int FRAME_W      = 640;
  localparam int FRAME_H      = 440;
  localparam int NUM_FRAMES   = 60;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam int TOTAL_PIXELS = FRAME_PIXELS * NUM_FRAMES;

  typedef logic [3:0] pix_t;

  typedef struct packed {
    pix_t       data;
    logic       sof;
    logic       eol;
    logic [7:0] frame;
  } pix_beat_t;
endpackage

// File: rtl/donut_pix_fifo.sv
// Two-entry pixel FIFO with flush; no empty-FIFO bypass, so output latency stays fixed.
module donut_pix_fifo
  import donut_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      flush_i,
  input  logic      push_i,
  input  pix_beat_t push_beat_i,
  input  logic      pop_i,
  output pix_beat_t head_o,
  output logic [1:0] occ_o
);
  pix_beat_t  r_mem [2];
  logic       r_rd_ptr;
  logic       r_wr_ptr;
  logic [1:0] r_occ;
  logic       w_push;
  logic       w_pop;

  assign w_push = push_i & (r_occ != 2'd2);
  assign w_pop  = pop_i & (r_occ != 2'd0);
  assign head_o = r_mem[r_rd_ptr];
  assign occ_o  = r_occ;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else if (flush_i) begin
      // Stale entries stay in r_mem but are unreachable once occupancy is zero.
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_beat_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/donut_frame_reader.sv
// Walks the frame ROM pixel by pixel and streams the words out with sof/eol/frame tags.
module donut_frame_reader #(
  parameter int FRAME_W     = donut_pkg::FRAME_W,
  parameter int FRAME_H     = donut_pkg::FRAME_H,
  parameter int NUM_FRAMES  = donut_pkg::NUM_FRAMES,
  parameter int HOLD_FRAMES = 1,
  parameter int DATA_W      = 4,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              restart_i,
  output logic              rom_cen_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_data_i,
  output logic [DATA_W-1:0] pix_data_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic              pix_sof_o,
  output logic              pix_eol_o,
  output logic [7:0]        frame_idx_o
);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(FRAME_W * FRAME_H);

  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    r_base;
  logic [15:0]          r_x;
  logic [15:0]          r_y;
  logic [7:0]           r_frame;
  logic [7:0]           r_hold;
  logic                 r_inflight;
  logic                 r_side_sof;
  logic                 r_side_eol;
  logic [7:0]           r_side_frame;

  logic [1:0]           w_occ;
  logic [2:0]           w_level;
  logic                 w_valid;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_sof_pix;
  logic                 w_eol_pix;
  logic                 w_eof;
  donut_pkg::pix_beat_t w_head;
  donut_pkg::pix_beat_t w_push_beat;

  // Stream handshake: a pixel moves when pix_valid_o & pix_ready_i; while valid is
  // high and ready is low, data and tags hold. Valid never depends on ready.
  assign w_valid = (w_occ != 2'd0);
  assign w_pop   = w_valid & pix_ready_i;

  // Slots already claimed after this cycle's pop; a new read needs one free slot.
  assign w_level = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue = ~rst_i & en_i & ~restart_i & (w_level < 3'd2);

  assign w_sof_pix = (r_x == 16'd0) && (r_y == 16'd0);
  assign w_eol_pix = (r_x == 16'(FRAME_W - 1));
  assign w_eof     = w_eol_pix && (r_y == 16'(FRAME_H - 1));

  assign w_push_beat = '{data: donut_pkg::pix_t'(rom_data_i), sof: r_side_sof,
                         eol: r_side_eol, frame: r_side_frame};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr       <= '0;
      r_base       <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_frame      <= '0;
      r_hold       <= '0;
      r_inflight   <= 1'b0;
      r_side_sof   <= 1'b0;
      r_side_eol   <= 1'b0;
      r_side_frame <= '0;
    end else if (restart_i) begin
      r_addr     <= '0;
      r_base     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_frame    <= '0;
      r_hold     <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_side_sof   <= w_sof_pix;
        r_side_eol   <= w_eol_pix;
        r_side_frame <= r_frame;
        if (w_eol_pix) begin
          r_x <= '0;
          r_y <= w_eof ? 16'd0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
        if (!w_eof) begin
          r_addr <= r_addr + 1'b1;
        end else if (r_hold != 8'(HOLD_FRAMES - 1)) begin
          r_hold <= r_hold + 8'd1;
          r_addr <= r_base;
        end else if (r_frame == 8'(NUM_FRAMES - 1)) begin
          r_hold  <= '0;
          r_frame <= '0;
          r_base  <= '0;
          r_addr  <= '0;
        end else begin
          r_hold  <= '0;
          r_frame <= r_frame + 8'd1;
          r_base  <= r_base + FRAME_STEP;
          r_addr  <= r_base + FRAME_STEP;
        end
      end
    end
  end

  donut_pix_fifo u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (restart_i),
    .push_i      (r_inflight),
    .push_beat_i (w_push_beat),
    .pop_i       (w_pop),
    .head_o      (w_head),
    .occ_o       (w_occ)
  );

  assign rom_cen_o   = w_issue;
  assign rom_addr_o  = r_addr;
  assign pix_valid_o = w_valid;
  assign pix_data_o  = w_valid ? DATA_W'(w_head.data) : '0;
  assign pix_sof_o   = w_valid & w_head.sof;
  assign pix_eol_o   = w_valid & w_head.eol;
  assign frame_idx_o = w_valid ? w_head.frame : 8'd0;
endmodule

// File: tb/tb_donut_frame_reader.sv
// Bench for donut_frame_reader: two instances (hold 1 and hold 2) on small geometry.
module tb_donut_frame_reader;
  localparam int FW = 4;
  localparam int FH = 2;
  localparam int NF = 3;
  localparam int FP = FW * FH;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ready;
  logic        restart;

  logic        cen0, cen1;
  logic [31:0] addr0, addr1;
  logic [3:0]  rom_q0 = 4'h0;
  logic [3:0]  rom_q1 = 4'h0;
  logic [3:0]  data0, data1;
  logic        valid0, valid1, sof0, sof1, eol0, eol1;
  logic [7:0]  frame0, frame1;
  logic [13:0] beat0, beat1;

  int checks = 0;
  int errors = 0;
  int iss_cnt [2];
  bit vlow_pend [2];
  int hold_of [2] = '{1, 2};
  logic [13:0] exp_q0 [$];
  logic [13:0] exp_q1 [$];

  always #5 clk = ~clk;

  donut_frame_reader #(.FRAME_W(FW), .FRAME_H(FH), .NUM_FRAMES(NF), .HOLD_FRAMES(1),
                       .DATA_W(4), .ADDR_W(32)) dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart),
    .rom_cen_o(cen0), .rom_addr_o(addr0), .rom_data_i(rom_q0),
    .pix_data_o(data0), .pix_valid_o(valid0), .pix_ready_i(ready),
    .pix_sof_o(sof0), .pix_eol_o(eol0), .frame_idx_o(frame0));

  donut_frame_reader #(.FRAME_W(FW), .FRAME_H(FH), .NUM_FRAMES(NF), .HOLD_FRAMES(2),
                       .DATA_W(4), .ADDR_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .restart_i(restart),
    .rom_cen_o(cen1), .rom_addr_o(addr1), .rom_data_i(rom_q1),
    .pix_data_o(data1), .pix_valid_o(valid1), .pix_ready_i(ready),
    .pix_sof_o(sof1), .pix_eol_o(eol1), .frame_idx_o(frame1));

  // ROM models: 1-cycle synchronous read, word = addr[3:0], output holds when not enabled.
  always @(posedge clk) if (cen0) rom_q0 <= addr0[3:0];
  always @(posedge clk) if (cen1) rom_q1 <= addr1[3:0];

  assign beat0 = {data0, sof0, eol0, frame0};
  assign beat1 = {data1, sof1, eol1, frame1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the m-th read since restart, from frame geometry and replay count.
  function automatic int exp_addr(int hold, int m);
    int pass  = m / FP;
    int frame = (pass / hold) % NF;
    return frame * FP + (m % FP);
  endfunction

  function automatic logic [13:0] exp_beat(int hold, int m);
    int         w     = m % FP;
    int         frame = ((m / FP) / hold) % NF;
    logic [3:0] d     = 4'(exp_addr(hold, m));
    logic       s     = (w == 0);
    logic       e     = ((w % FW) == FW - 1);
    return {d, s, e, 8'(frame)};
  endfunction

  function automatic void q_push(int d, logic [13:0] v);
    if (d == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction

  function automatic logic [13:0] q_pop(int d);
    if (d == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic int q_size(int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void q_clear(int d);
    if (d == 0) exp_q0.delete(); else exp_q1.delete();
  endfunction

  task automatic observe(input int d, input logic cen, input logic [31:0] addr,
                         input logic valid, input logic [13:0] beat);
    if (rst) begin
      q_clear(d);
      iss_cnt[d]   = 0;
      vlow_pend[d] = 1'b0;
      return;
    end
    if (vlow_pend[d]) begin
      check($sformatf("valid_after_restart%0d", d), 32'(valid), 32'd0);
      vlow_pend[d] = 1'b0;
    end
    if (valid && ready) begin
      if (q_size(d) == 0) check($sformatf("spurious_pixel%0d", d), 32'(beat), 32'hFFFF);
      else check($sformatf("pixel%0d", d), 32'(beat), 32'(q_pop(d)));
    end
    if (restart) begin
      check($sformatf("cen_in_restart%0d", d), 32'(cen), 32'd0);
      q_clear(d);
      iss_cnt[d]   = 0;
      vlow_pend[d] = 1'b1;
    end else if (cen) begin
      check($sformatf("issue_addr%0d", d), addr, 32'(exp_addr(hold_of[d], iss_cnt[d])));
      q_push(d, exp_beat(hold_of[d], iss_cnt[d]));
      iss_cnt[d]++;
    end
    check($sformatf("outstanding%0d", d), 32'(q_size(d) <= 2), 32'd1);
  endtask

  always @(negedge clk) begin
    observe(0, cen0, addr0, valid0, beat0);
    observe(1, cen1, addr1, valid1, beat1);
  end

  task automatic check_zero(input string tag);
    check({tag, "_cen"},   32'({cen0, cen1}),     32'd0);
    check({tag, "_addr"},  addr0 | addr1,         32'd0);
    check({tag, "_valid"}, 32'({valid0, valid1}), 32'd0);
    check({tag, "_data"},  32'({data0, data1}),   32'd0);
    check({tag, "_tags"},  32'({sof0, eol0, sof1, eol1}), 32'd0);
    check({tag, "_frame"}, 32'({frame0, frame1}), 32'd0);
  endtask

  logic [13:0] held;

  initial begin
    rst = 1'b1; en = 1'b1; ready = 1'b1; restart = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // First read at cycle 0, first pixel two cycles later.
    @(negedge clk);
    check("c0_cen", 32'(cen0), 32'd1);
    check("c0_addr", addr0, 32'd0);
    check("c0_valid", 32'(valid0), 32'd0);
    @(negedge clk);
    check("c1_valid", 32'(valid0), 32'd0);
    check("c1_addr", addr0, 32'd1);
    @(negedge clk);
    check("c2_valid", 32'(valid0), 32'd1);
    check("c2_beat", 32'(beat0), 32'({4'd0, 1'b1, 1'b0, 8'd0}));
    repeat (30) begin
      @(negedge clk);
      check("steady_cen", 32'({cen0, cen1}), 32'd3);
    end

    // Consumer stall mid-line.
    @(posedge clk); #1 ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) held = beat0;
      else begin
        check("stall_valid", 32'(valid0), 32'd1);
        check("stall_hold", 32'(beat0), 32'(held));
      end
      if (k >= 3) check("stall_cen", 32'(cen0), 32'd0);
    end
    @(posedge clk); #1 ready = 1'b1;
    repeat (20) @(negedge clk);

    // Restart with a full FIFO and consumer stalled.
    @(posedge clk); #1 ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("restart_next_cen", 32'(cen0), 32'd1);
    check("restart_next_addr", addr0, 32'd0);
    repeat (20) @(negedge clk);

    // Play disable with two buffered pixels.
    @(posedge clk); #1 ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 en = 1'b0; ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("en_low_cen", 32'(cen0), 32'd0);
      if (k >= 3) check("en_low_drained", 32'(valid0), 32'd0);
    end
    @(posedge clk); #1 en = 1'b1;
    repeat (20) @(negedge clk);

    // Asynchronous reset between clock edges.
    @(posedge clk); #3 rst = 1'b1;
    #1 check_zero("async_rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(negedge clk);

    // Random ready / enable / restart traffic.
    repeat (1500) begin
      @(posedge clk); #1;
      ready   = ($urandom_range(0, 3) != 0);
      en      = ($urandom_range(0, 7) != 0);
      restart = ($urandom_range(0, 63) == 0);
    end
    @(posedge clk); #1 restart = 1'b0; en = 1'b1; ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
